simt_register_file: RTL and testbench

// - Per-warp, per-lane vector register file. Responder to the SIMT writeback stage's masked write port.
// - Serves two synchronous read ports (rs1, rs2) to the operand-fetch stage.
// - Clears every row to zero after reset via a sweep FSM, then signals ready.
// - x0 is hardwired to zero for every warp.

---
 rtl/simt_register_file_pkg.sv | 18 +
 rtl/simt_rf_lane_bank.sv | 45 ++++
 rtl/simt_register_file.sv | 146 ++++++++++++++
 tb/tb_simt_register_file.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simt_register_file_pkg.sv
// Shared geometry, lane-vector type and FSM state encoding for the SIMT vector register file.
package simt_register_file_pkg;

    localparam int unsigned NUM_WARPS      = 8;
    localparam int unsigned WARP_SIZE      = 32;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned NUM_REGS       = 32;
    localparam int unsigned WARP_ID_WIDTH  = $clog2(NUM_WARPS);
    localparam int unsigned REG_ADDR_WIDTH = $clog2(NUM_REGS);

    typedef logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] lane_vec_t;

    typedef enum logic {
        RF_CLEAR,
        RF_READY
    } rf_state_e;

endpackage

// File: rtl/simt_rf_lane_bank.sv
// Storage for one lane: all {warp, reg} rows, one write port and two registered read ports.
module simt_rf_lane_bank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    input  logic                  byp1,
    input  logic                  byp2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata1_q, rdata2_q;

    // Contents need no reset: the top sweeps every row to zero after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A bypassed port takes the word being written this edge instead of the stale row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else if (re) begin
            rdata1_q <= byp1 ? wdata : mem[raddr1];
            rdata2_q <= byp2 ? wdata : mem[raddr2];
        end
    end

    assign rdata1 = rdata1_q;
    assign rdata2 = rdata2_q;

endmodule

// File: rtl/simt_register_file.sv
// Per-warp, per-lane vector register file: masked write port, two registered read ports with
// write-through bypass, and a zeroing sweep after reset or on clear_req.
module simt_register_file
    import simt_register_file_pkg::*;
#(
    parameter int unsigned NUM_WARPS      = simt_register_file_pkg::NUM_WARPS,
    parameter int unsigned WARP_SIZE      = simt_register_file_pkg::WARP_SIZE,
    parameter int unsigned DATA_WIDTH     = simt_register_file_pkg::DATA_WIDTH,
    parameter int unsigned NUM_REGS       = simt_register_file_pkg::NUM_REGS,
    parameter int unsigned WARP_ID_WIDTH  = $clog2(NUM_WARPS),
    parameter int unsigned REG_ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear_req,
    output logic                            rf_ready,
    input  logic [WARP_ID_WIDTH-1:0]        wr_warp_id,
    input  logic [REG_ADDR_WIDTH-1:0]       wr_rd_addr,
    input  logic [WARP_SIZE*DATA_WIDTH-1:0] wr_data,
    input  logic [WARP_SIZE-1:0]            wr_mask,
    input  logic                            wr_en,
    input  logic                            rd_en,
    input  logic [WARP_ID_WIDTH-1:0]        rd_warp_id,
    input  logic [REG_ADDR_WIDTH-1:0]       rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0]       rs2_addr,
    output logic [WARP_SIZE*DATA_WIDTH-1:0] rs1_data,
    output logic [WARP_SIZE*DATA_WIDTH-1:0] rs2_data,
    output logic                            rd_valid
);

    localparam int unsigned NUM_ROWS  = NUM_WARPS * NUM_REGS;
    localparam int unsigned ROW_WIDTH = WARP_ID_WIDTH + REG_ADDR_WIDTH;
    localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(NUM_ROWS - 1);

    rf_state_e            state_q, state_d;
    logic [ROW_WIDTH-1:0] idx_q, idx_d;
    logic                 sweeping;
    logic                 rd_valid_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RF_CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            RF_CLEAR: begin
                idx_d = idx_q + ROW_WIDTH'(1);
                if (idx_q == LAST_ROW) begin
                    state_d = RF_READY;
                    idx_d   = '0;
                end
            end
            RF_READY: begin
                if (clear_req) begin
                    state_d = RF_CLEAR;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = RF_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        rf_ready = 1'b0;
        sweeping = 1'b0;
        unique case (state_q)
            RF_CLEAR: sweeping = 1'b1;
            RF_READY: rf_ready = 1'b1;
            default:  sweeping = 1'b1;
        endcase
    end

    logic                 wr_go, rd_go;
    logic                 hit1, hit2;
    logic [ROW_WIDTH-1:0] wr_row, rs1_row, rs2_row, bank_waddr;

    assign wr_row  = {wr_warp_id, wr_rd_addr};
    assign rs1_row = {rd_warp_id, rs1_addr};
    assign rs2_row = {rd_warp_id, rs2_addr};

    // x0 stays zero because writes to it are dropped and the sweep clears it.
    assign wr_go = rf_ready && wr_en && (wr_rd_addr != '0);
    assign rd_go = rf_ready && rd_en;

    // wr_go already excludes x0, so a hit implies a non-zero read address.
    assign hit1 = wr_go && (rd_warp_id == wr_warp_id) && (rs1_addr == wr_rd_addr);
    assign hit2 = wr_go && (rd_warp_id == wr_warp_id) && (rs2_addr == wr_rd_addr);

    assign bank_waddr = sweeping ? idx_q : wr_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_go;
        end
    end

    assign rd_valid = rd_valid_q;

    for (genvar i = 0; i < WARP_SIZE; i++) begin : g_lane
        logic                  lane_we;
        logic [DATA_WIDTH-1:0] lane_wdata;
        logic [DATA_WIDTH-1:0] lane_rd1, lane_rd2;

        assign lane_we    = sweeping || (wr_go && wr_mask[i]);
        assign lane_wdata = sweeping ? '0 : wr_data[i*DATA_WIDTH +: DATA_WIDTH];

        simt_rf_lane_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (NUM_ROWS),
            .ADDR_WIDTH (ROW_WIDTH)
        ) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .we     (lane_we),
            .waddr  (bank_waddr),
            .wdata  (lane_wdata),
            .re     (rd_go),
            .raddr1 (rs1_row),
            .raddr2 (rs2_row),
            .byp1   (hit1 && wr_mask[i]),
            .byp2   (hit2 && wr_mask[i]),
            .rdata1 (lane_rd1),
            .rdata2 (lane_rd2)
        );

        assign rs1_data[i*DATA_WIDTH +: DATA_WIDTH] = lane_rd1;
        assign rs2_data[i*DATA_WIDTH +: DATA_WIDTH] = lane_rd2;
    end

endmodule

// File: tb/tb_simt_register_file.sv
// Randomized scoreboard bench for simt_register_file against an array model of the register file.
module tb_simt_register_file;

    localparam int NW = 8;
    localparam int WS = 32;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int VW = WS * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear_req;
    logic          rf_ready;
    logic [2:0]    wr_warp_id;
    logic [4:0]    wr_rd_addr;
    logic [VW-1:0] wr_data;
    logic [WS-1:0] wr_mask;
    logic          wr_en;
    logic          rd_en;
    logic [2:0]    rd_warp_id;
    logic [4:0]    rs1_addr;
    logic [4:0]    rs2_addr;
    logic [VW-1:0] rs1_data;
    logic [VW-1:0] rs2_data;
    logic          rd_valid;

    simt_register_file dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_req  (clear_req),
        .rf_ready   (rf_ready),
        .wr_warp_id (wr_warp_id),
        .wr_rd_addr (wr_rd_addr),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .rd_warp_id (rd_warp_id),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rd_valid   (rd_valid)
    );

    always #5 clk = ~clk;

    int check_cnt = 0;
    int fail_cnt  = 0;
    int low_cnt   = 0;

    logic [DW-1:0] model [NW][NR][WS];
    logic [VW-1:0] q1[$];
    logic [VW-1:0] q2[$];

    task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        int bad;
        bad = -1;
        check_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            for (int l = WS - 1; l >= 0; l--) begin
                if (act[l*DW +: DW] !== exp[l*DW +: DW]) bad = l;
            end
            $display("FAIL %s: lane %0d got %h expected %h", name, bad,
                     act[bad*DW +: DW], exp[bad*DW +: DW]);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] model_row(input int w, input int r);
        logic [VW-1:0] v;
        for (int l = 0; l < WS; l++) v[l*DW +: DW] = model[w][r][l];
        return v;
    endfunction

    function automatic logic [VW-1:0] fill(input logic [DW-1:0] word);
        logic [VW-1:0] v;
        for (int l = 0; l < WS; l++) v[l*DW +: DW] = word;
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int l = 0; l < WS; l++) v[l*DW +: DW] = $urandom;
        return v;
    endfunction

    task automatic zero_model();
        for (int w = 0; w < NW; w++)
            for (int r = 0; r < NR; r++)
                for (int l = 0; l < WS; l++) model[w][r][l] = '0;
    endtask

    // One cycle of stimulus; the model only changes when the DUT is ready to accept it.
    task automatic issue(input logic we, input int ww, input int wr, input logic [VW-1:0] wd,
                         input logic [WS-1:0] wm, input logic re, input int rw, input int r1,
                         input int r2, input logic clr);
        wr_en      = we;
        wr_warp_id = 3'(ww);
        wr_rd_addr = 5'(wr);
        wr_data    = wd;
        wr_mask    = wm;
        rd_en      = re;
        rd_warp_id = 3'(rw);
        rs1_addr   = 5'(r1);
        rs2_addr   = 5'(r2);
        clear_req  = clr;
        if (rf_ready) begin
            if (we && wr != 0) begin
                for (int l = 0; l < WS; l++) if (wm[l]) model[ww][wr][l] = wd[l*DW +: DW];
            end
            if (re) begin
                q1.push_back(model_row(rw, r1));
                q2.push_back(model_row(rw, r2));
            end
            if (clr) zero_model();
        end
        @(posedge clk);
        #1;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int g;
        g = 0;
        while (!rf_ready && g < 2000) begin
            @(posedge clk);
            #1;
            g++;
        end
        check_val({name, "_ready"}, 32'(rf_ready), 32'd1);
        check_val({name, "_len"}, 32'(low_cnt), 32'd256);
    endtask

    task automatic idle(input int n);
        repeat (n) issue(1'b0, 0, 0, '0, '0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rf_ready === 1'b0) low_cnt++;
    end

    // Monitor: every valid read response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rd_valid === 1'b1) begin
            if (q1.size() == 0) begin
                check_cnt++;
                fail_cnt++;
                $display("FAIL unexpected_rd_valid: got 1 expected 0");
            end else begin
                check_vec("rs1_data", rs1_data, q1.pop_front());
                check_vec("rs2_data", rs2_data, q2.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] v;
        logic [WS-1:0] m;
        int g;

        rst_n = 1'b0;
        clear_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_warp_id = '0; wr_rd_addr = '0; wr_data = '0; wr_mask = '0;
        rd_warp_id = '0; rs1_addr = '0; rs2_addr = '0;
        zero_model();
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_rf_ready", 32'(rf_ready), 32'd0);
        check_val("reset_rd_valid", 32'(rd_valid), 32'd0);
        check_vec("reset_rs1", rs1_data, '0);
        check_vec("reset_rs2", rs2_data, '0);
        rst_n = 1'b1;
        low_cnt = 0;
        wait_ready("reset_sweep");

        issue(1'b0, 0, 0, '0, '0, 1'b1, 3, 5, 5, 1'b0);
        for (int l = 0; l < WS; l++) v[l*DW +: DW] = 32'h100 + 32'(l);
        issue(1'b1, 2, 7, v, 32'h0000_FFFF, 1'b0, 0, 0, 0, 1'b0);
        issue(1'b0, 0, 0, '0, '0, 1'b1, 2, 7, 0, 1'b0);
        issue(1'b1, 0, 0, fill(32'hDEAD_BEEF), '1, 1'b0, 0, 0, 0, 1'b0);
        issue(1'b0, 0, 0, '0, '0, 1'b1, 0, 0, 7, 1'b0);
        issue(1'b1, 1, 4, fill(32'hAAAA_AAAA), '1, 1'b0, 0, 0, 0, 1'b0);
        issue(1'b1, 1, 4, fill(32'h5555_5555), 32'hFFFF_0000, 1'b1, 1, 4, 4, 1'b0);
        issue(1'b1, 5, 9, fill(32'h1234), '1, 1'b0, 0, 0, 0, 1'b0);
        issue(1'b0, 0, 0, '0, '0, 1'b1, 4, 9, 9, 1'b0);
        issue(1'b0, 0, 0, '0, '0, 1'b1, 5, 9, 0, 1'b0);
        issue(1'b0, 0, 0, '0, '0, 1'b1, 2, 7, 4, 1'b0);

        // Narrow address ranges make same-cycle write/read hazards common.
        for (int i = 0; i < 400; i++) begin
            int ww, wr, rw, r1, r2;
            ww = int'($urandom_range(0, 2));
            rw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NW - 1)) : ww;
            wr = int'($urandom_range(0, 5));
            r1 = int'($urandom_range(0, 5));
            r2 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NR - 1)) : int'($urandom_range(0, 5));
            case ($urandom_range(0, 3))
                0: m = '1;
                1: m = '0;
                default: m = $urandom;
            endcase
            issue(1'($urandom), ww, wr, rand_vec(), m, 1'($urandom), rw, r1, r2, 1'b0);
        end
        idle(3);

        // clear_req with a same-cycle write and read, then ops that must be ignored mid-sweep.
        check_val("pre_clear_ready", 32'(rf_ready), 32'd1);
        issue(1'b1, 6, 3, rand_vec(), '1, 1'b1, 1, 4, 9, 1'b1);
        low_cnt = 0;
        for (int i = 0; i < 6; i++)
            issue(1'b1, 0, 1, fill(32'hBAD0_0000 + 32'(i)), '1, 1'b1, 0, 1, 1, 1'b0);
        wait_ready("clear_sweep");
        for (int w = 0; w < NW; w++)
            for (int r = 0; r < NR; r++)
                issue(1'b0, 0, 0, '0, '0, 1'b1, w, r, (r + 1) % NR, 1'b0);
        idle(2);

        // Second clear, interrupted by reset at sweep cycle 100.
        issue(1'b1, 7, 31, fill(32'hFFFF_FFFF), '1, 1'b0, 0, 0, 0, 1'b0);
        issue(1'b0, 0, 0, '0, '0, 1'b1, 7, 31, 31, 1'b1);
        low_cnt = 0;
        g = 0;
        while (low_cnt < 100 && g < 1000) begin
            @(negedge clk);
            #1;
            g++;
        end
        check_val("mid_sweep_reached", 32'(low_cnt), 32'd100);
        check_val("queue_before_reset", 32'(q1.size()), 32'd0);
        rst_n = 1'b0;
        #1;
        check_val("midreset_rf_ready", 32'(rf_ready), 32'd0);
        check_val("midreset_rd_valid", 32'(rd_valid), 32'd0);
        check_vec("midreset_rs1", rs1_data, '0);
        check_vec("midreset_rs2", rs2_data, '0);
        zero_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        low_cnt = 0;
        wait_ready("restart_sweep");
        for (int i = 0; i < 16; i++)
            issue(1'b0, 0, 0, '0, '0, 1'b1, i % NW, 31 - i, i, 1'b0);
        idle(3);

        check_val("queue_drained", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
        $finish;
    end

endmodule
